alu_issue_ctrl: RTL

Sequential issue controller that drives the 4-bit selector of the datapath ALU result multiplexer. It accepts ARMv4 data-processing instructions over a valid/ready handshake and decodes the opcode and shifter-operand fields. It emits one or two registered ALU control beats per instruction: an optional shift pass followed by the operation pass. It sits between the decode stage and the ALU; condition-code evaluation is done upstream.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_issue_ctrl_if.sv | 32 +++
 rtl/alu_cmd_decode.sv | 88 ++++++++
 rtl/alu_issue_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue controller: mux selector codes, ARM data-processing
// opcodes, shifter types, FSM states and the latched per-instruction control fields.
package alu_pkg;

    typedef enum logic [3:0] {
        SEL_ADD = 4'd0,
        SEL_SUB = 4'd1,
        SEL_AND = 4'd2,
        SEL_ORR = 4'd4,
        SEL_EOR = 4'd5,
        SEL_LSL = 4'd6,
        SEL_LSR = 4'd7,
        SEL_ASR = 4'd8
    } alu_sel_e;

    typedef enum logic [3:0] {
        CMD_AND = 4'd0,  CMD_EOR = 4'd1,  CMD_SUB = 4'd2,  CMD_RSB = 4'd3,
        CMD_ADD = 4'd4,  CMD_ADC = 4'd5,  CMD_SBC = 4'd6,  CMD_RSC = 4'd7,
        CMD_TST = 4'd8,  CMD_TEQ = 4'd9,  CMD_CMP = 4'd10, CMD_CMN = 4'd11,
        CMD_ORR = 4'd12, CMD_MOV = 4'd13, CMD_BIC = 4'd14, CMD_MVN = 4'd15
    } dp_cmd_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OP    = 2'd2
    } issue_state_e;

    typedef struct packed {
        alu_sel_e   alu_sel;
        logic       swap_ab;
        logic       a_zero;
        logic       result_we;
        logic       flag_we;
        logic       needs_shift;
        alu_sel_e   shift_sel;
        logic       illegal;
        logic [4:0] shamt_imm;
        logic       shamt_reg;
    } issue_fields_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-in / ALU-control-out handshake bundle between decode and the ALU issue controller.
// The master side is the decode/ALU environment; the slave side is the controller.
interface alu_issue_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_sel;
    logic        shift_pass;
    logic [4:0]  shamt_imm;
    logic        shamt_reg;
    logic        swap_ab;
    logic        a_zero;
    logic        result_we;
    logic        flag_we;
    logic        illegal;

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, alu_sel, shift_pass, shamt_imm, shamt_reg,
               swap_ab, a_zero, result_we, flag_we, illegal
    );

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, alu_sel, shift_pass, shamt_imm, shamt_reg,
               swap_ab, a_zero, result_we, flag_we, illegal
    );

endinterface

// File: rtl/alu_cmd_decode.sv
// Combinational decode of an ARMv4 data-processing word into ALU control fields.
// Illegal instructions come out with every control field cleared apart from illegal.
module alu_cmd_decode
    import alu_pkg::*;
#(
    parameter bit ENABLE_SHIFT_PASS = 1'b1
) (
    input  logic [31:0] instr,
    output alu_sel_e    alu_sel,
    output logic        swap_ab,
    output logic        a_zero,
    output logic        result_we,
    output logic        flag_we,
    output logic        needs_shift,
    output alu_sel_e    shift_sel,
    output logic        illegal
);

    dp_cmd_e     cmd;
    shift_type_e sh_type;
    alu_sel_e    op_sel;
    logic        op_swap;
    logic        op_azero;
    logic        op_we;
    logic        op_compare;
    logic        cmd_ok;
    logic        shift_ok;
    logic        shift_req;
    logic        unused_instr_bits;

    assign unused_instr_bits = ^{instr[31:26], instr[19:12], instr[3:0]};

    always_comb begin
        cmd        = dp_cmd_e'(instr[24:21]);
        sh_type    = shift_type_e'(instr[6:5]);
        op_sel     = SEL_ADD;
        op_swap    = 1'b0;
        op_azero   = 1'b0;
        op_we      = 1'b0;
        op_compare = 1'b0;
        cmd_ok     = 1'b1;
        case (cmd)
            CMD_AND: begin op_sel = SEL_AND; op_we = 1'b1; end
            CMD_EOR: begin op_sel = SEL_EOR; op_we = 1'b1; end
            CMD_SUB: begin op_sel = SEL_SUB; op_we = 1'b1; end
            CMD_RSB: begin op_sel = SEL_SUB; op_we = 1'b1; op_swap = 1'b1; end
            CMD_ADD: begin op_sel = SEL_ADD; op_we = 1'b1; end
            CMD_TST: begin op_sel = SEL_AND; op_compare = 1'b1; end
            CMD_TEQ: begin op_sel = SEL_EOR; op_compare = 1'b1; end
            CMD_CMP: begin op_sel = SEL_SUB; op_compare = 1'b1; end
            CMD_CMN: begin op_sel = SEL_ADD; op_compare = 1'b1; end
            CMD_ORR: begin op_sel = SEL_ORR; op_we = 1'b1; end
            CMD_MOV: begin op_sel = SEL_ADD; op_we = 1'b1; op_azero = 1'b1; end
            default: cmd_ok = 1'b0;
        endcase

        // A register-specified shift always needs the pass, even if Rs holds zero at runtime.
        shift_req = ~instr[25] & (instr[4] | (instr[11:7] != 5'd0));
        shift_ok  = ENABLE_SHIFT_PASS;
        shift_sel = SEL_LSL;
        case (sh_type)
            SH_LSL:  shift_sel = SEL_LSL;
            SH_LSR:  shift_sel = SEL_LSR;
            SH_ASR:  shift_sel = SEL_ASR;
            default: shift_ok  = 1'b0;
        endcase

        illegal = ~cmd_ok | (shift_req & ~shift_ok);

        if (illegal) begin
            alu_sel     = SEL_ADD;
            swap_ab     = 1'b0;
            a_zero      = 1'b0;
            result_we   = 1'b0;
            flag_we     = 1'b0;
            needs_shift = 1'b0;
            shift_sel   = SEL_LSL;
        end else begin
            alu_sel     = op_sel;
            swap_ab     = op_swap;
            a_zero      = op_azero;
            result_we   = op_we;
            flag_we     = instr[20] | op_compare;
            needs_shift = shift_req;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one data-processing instruction in IDLE, then emits an optional
// shift-pass beat and the operation beat, all driven from registered state only.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter bit ENABLE_SHIFT_PASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    alu_issue_ctrl_if.slave  bus
);

    issue_state_e  state;
    issue_state_e  state_next;
    issue_fields_t dec;
    issue_fields_t held;
    logic          accept;

    alu_cmd_decode #(
        .ENABLE_SHIFT_PASS(ENABLE_SHIFT_PASS)
    ) u_decode (
        .instr       (bus.instr),
        .alu_sel     (dec.alu_sel),
        .swap_ab     (dec.swap_ab),
        .a_zero      (dec.a_zero),
        .result_we   (dec.result_we),
        .flag_we     (dec.flag_we),
        .needs_shift (dec.needs_shift),
        .shift_sel   (dec.shift_sel),
        .illegal     (dec.illegal)
    );

    assign dec.shamt_imm = bus.instr[11:7];
    assign dec.shamt_reg = bus.instr[4];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            held  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                held <= dec;
            end
        end
    end

    // Beat fields come only from the latched fields, so they hold steady under back-pressure.
    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.alu_sel    = 4'd0;
        bus.shift_pass = 1'b0;
        bus.shamt_imm  = 5'd0;
        bus.shamt_reg  = 1'b0;
        bus.swap_ab    = 1'b0;
        bus.a_zero     = 1'b0;
        bus.result_we  = 1'b0;
        bus.flag_we    = 1'b0;
        bus.illegal    = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = dec.needs_shift ? SHIFT : OP;
                end
            end
            SHIFT: begin
                bus.out_valid  = 1'b1;
                bus.shift_pass = 1'b1;
                bus.alu_sel    = held.shift_sel;
                bus.shamt_imm  = held.shamt_imm;
                bus.shamt_reg  = held.shamt_reg;
                if (bus.out_ready) begin
                    state_next = OP;
                end
            end
            OP: begin
                bus.out_valid = 1'b1;
                bus.alu_sel   = held.alu_sel;
                bus.swap_ab   = held.swap_ab;
                bus.a_zero    = held.a_zero;
                bus.result_we = held.result_we;
                bus.flag_we   = held.flag_we;
                bus.illegal   = held.illegal;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
